// File: rtl/fc3_pkg.sv
`default_nettype none
// ============================================================================
// Module : fc3_pkg
// Brief  : Shared widths, FSM state encoding and saturate/truncate helper for
//          the FC3 multiply-accumulate engine.
// Rev    : 1.0  initial release
// ============================================================================
package fc3_pkg;

  localparam int DEF_WDP_WEIGHT = 18;
  localparam int DEF_WDP_ACT    = 16;
  localparam int DEF_N_IN       = 16;
  localparam int DEF_N_OUT      = 2;
  localparam int DEF_NUM_STEPS  = 24;
  localparam int DEF_SHIFT      = 16;
  localparam int DEF_WDP_OUT    = 32;

  localparam int DOT_W = DEF_WDP_ACT + DEF_WDP_WEIGHT + $clog2(DEF_N_IN);
  localparam int ACC_W = DEF_WDP_ACT + DEF_WDP_WEIGHT + $clog2(DEF_N_IN * DEF_NUM_STEPS);

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_FETCH = 3'd1,
    S_MUL   = 3'd2,
    S_ACC   = 3'd3,
    S_OUT   = 3'd4
  } fc3_state_t;

  // Clamp to a signed wout-bit range when sat_en is set; otherwise pass the
  // value through so the caller's low-bit slice yields a two's-complement wrap.
  function automatic logic signed [63:0] fc3_sat(input logic signed [63:0] v,
                                                 input int                 wout,
                                                 input logic               sat_en);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (wout - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    fc3_sat = v;
    if (sat_en) begin
      if (v > hi)      fc3_sat = hi;
      else if (v < lo) fc3_sat = lo;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/fc3_dot_unit.sv
`default_nettype none
// ============================================================================
// Module : fc3_dot_unit
// Brief  : Combinational N_IN-wide signed dot product for one FC3 output.
//          Element 0 of both operand vectors sits in the MSB slice.
// Rev    : 1.0  initial release
// ============================================================================
module fc3_dot_unit #(
  parameter int WDP_WEIGHT = 18,
  parameter int WDP_ACT    = 16,
  parameter int N_IN       = 16,
  parameter int DOT_W      = WDP_ACT + WDP_WEIGHT + $clog2(N_IN)
) (
  input  logic        [WDP_ACT*N_IN-1:0]    act,
  input  logic        [WDP_WEIGHT*N_IN-1:0] w,
  output logic signed [DOT_W-1:0]           dot
);

  logic signed [DOT_W-1:0] w_prod [N_IN];

  for (genvar i = 0; i < N_IN; i++) begin : g_mul
    assign w_prod[i] = DOT_W'($signed(act[(N_IN-1-i)*WDP_ACT +: WDP_ACT]))
                     * DOT_W'($signed(w[(N_IN-1-i)*WDP_WEIGHT +: WDP_WEIGHT]));
  end

  always_comb begin
    dot = '0;
    for (int i = 0; i < N_IN; i++) begin
      dot = dot + w_prod[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fc3_mac_engine.sv
`default_nettype none
// ============================================================================
// Module : fc3_mac_engine
// Brief  : FC3 step sequencer and MAC datapath: one ROM word per activation
//          vector, NUM_STEPS steps per frame, shifted class scores out.
//          Define FC3_SAT_EN to saturate results instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
module fc3_mac_engine
  import fc3_pkg::*;
#(
  parameter int WDP_WEIGHT = DEF_WDP_WEIGHT,
  parameter int WDP_ACT    = DEF_WDP_ACT,
  parameter int N_IN       = DEF_N_IN,
  parameter int N_OUT      = DEF_N_OUT,
  parameter int NUM_STEPS  = DEF_NUM_STEPS,
  parameter int SHIFT      = DEF_SHIFT,
  parameter int WDP_OUT    = DEF_WDP_OUT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WDP_ACT*N_IN-1:0]          in_act,
  output logic [11:0]                      rom_aa,
  output logic                             rom_cena,
  input  logic [WDP_WEIGHT*N_IN*N_OUT-1:0] rom_qa,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WDP_OUT*N_OUT-1:0]         out_data
);

  localparam int          c_DOT_W   = WDP_ACT + WDP_WEIGHT + $clog2(N_IN);
  localparam int          c_ACC_W   = WDP_ACT + WDP_WEIGHT + $clog2(N_IN * NUM_STEPS);
  localparam int          c_W_SLICE = WDP_WEIGHT * N_IN;
  localparam logic [11:0] c_LAST    = 12'(NUM_STEPS - 1);
`ifdef FC3_SAT_EN
  localparam logic        c_SAT_EN  = 1'b1;
`else
  localparam logic        c_SAT_EN  = 1'b0;
`endif

  fc3_state_t                r_state;
  logic [11:0]               r_step;
  logic [WDP_ACT*N_IN-1:0]   r_act;
  logic                      r_in_ready;
  logic                      r_rom_cena;
  logic                      r_out_valid;
  logic [WDP_OUT*N_OUT-1:0]  r_out_data;
  logic signed [c_DOT_W-1:0] r_dot [N_OUT];
  logic signed [c_ACC_W-1:0] r_acc [N_OUT];

  logic signed [c_DOT_W-1:0] w_dot [N_OUT];
  logic signed [c_ACC_W-1:0] w_sum [N_OUT];
  logic [WDP_OUT-1:0]        w_res [N_OUT];

  for (genvar o = 0; o < N_OUT; o++) begin : g_dot
    fc3_dot_unit #(
      .WDP_WEIGHT (WDP_WEIGHT),
      .WDP_ACT    (WDP_ACT),
      .N_IN       (N_IN),
      .DOT_W      (c_DOT_W)
    ) u_dot (
      .act (r_act),
      .w   (rom_qa[(N_OUT-1-o)*c_W_SLICE +: c_W_SLICE]),
      .dot (w_dot[o])
    );
  end

  // Final scores are formed from the sum being written this cycle, so the
  // result register loads on the same edge as the last accumulation.
  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      w_sum[o] = r_acc[o] + c_ACC_W'(r_dot[o]);
      w_res[o] = WDP_OUT'(fc3_sat(64'(w_sum[o] >>> SHIFT), WDP_OUT, c_SAT_EN));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_WAIT;
      r_step      <= '0;
      r_act       <= '0;
      r_in_ready  <= 1'b1;
      r_rom_cena  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      for (int o = 0; o < N_OUT; o++) begin
        r_dot[o] <= '0;
        r_acc[o] <= '0;
      end
    end else begin
      case (r_state)
        S_WAIT: begin
          if (in_valid) begin
            r_act      <= in_act;
            r_in_ready <= 1'b0;
            r_rom_cena <= 1'b0;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_rom_cena <= 1'b1;
          r_state    <= S_MUL;
        end
        S_MUL: begin
          for (int o = 0; o < N_OUT; o++) r_dot[o] <= w_dot[o];
          r_state <= S_ACC;
        end
        S_ACC: begin
          for (int o = 0; o < N_OUT; o++) r_acc[o] <= w_sum[o];
          if (r_step == c_LAST) begin
            for (int o = 0; o < N_OUT; o++)
              r_out_data[(N_OUT-1-o)*WDP_OUT +: WDP_OUT] <= w_res[o];
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_step     <= r_step + 12'd1;
            r_in_ready <= 1'b1;
            r_state    <= S_WAIT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            for (int o = 0; o < N_OUT; o++) r_acc[o] <= '0;
            r_step      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_WAIT;
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign rom_aa    = r_step;
  assign rom_cena  = r_rom_cena;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_fc3_mac_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_fc3_mac_engine
// Brief  : Self-checking bench; two engines (SHIFT 0 and 16) share stimulus,
//          each with its own behavioural registered ROM.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fc3_mac_engine;

  localparam int WW = 18;
  localparam int WA = 16;
  localparam int NI = 16;
  localparam int NO = 2;
  localparam int NS = 24;
  localparam int WO = 32;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic [WA*NI-1:0] in_act;

  logic             in_ready0, rom_cena0, out_valid0;
  logic [11:0]      rom_aa0;
  logic [WW*NI*NO-1:0] rom_qa0;
  logic [WO*NO-1:0] out_data0;
  logic             in_ready1, rom_cena1, out_valid1;
  logic [11:0]      rom_aa1;
  logic [WW*NI*NO-1:0] rom_qa1;
  logic [WO*NO-1:0] out_data1;

  always #5 clk = ~clk;

  fc3_mac_engine #(.WDP_WEIGHT(WW), .WDP_ACT(WA), .N_IN(NI), .N_OUT(NO),
                   .NUM_STEPS(NS), .SHIFT(0), .WDP_OUT(WO)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_act(in_act), .rom_aa(rom_aa0), .rom_cena(rom_cena0), .rom_qa(rom_qa0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0));

  fc3_mac_engine #(.WDP_WEIGHT(WW), .WDP_ACT(WA), .N_IN(NI), .N_OUT(NO),
                   .NUM_STEPS(NS), .SHIFT(16), .WDP_OUT(WO)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_act(in_act), .rom_aa(rom_aa1), .rom_cena(rom_cena1), .rom_qa(rom_qa1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1));

  // ---------------- stimulus model ----------------
  int cur_mode = 0;

  function automatic int act_of(input int mode, input int i);
    case (mode)
      2:       return -32768;
      3:       return i * 4099 - 30000;
      4:       return -1;
      default: return 1;
    endcase
  endfunction

  function automatic int wgt(input int mode, input int step, input int o, input int i);
    case (mode)
      1:       return step * (o + 1);
      2:       return -131072;
      3:       return ((step * 7919 + o * 104729 + i * 613) % 200001) - 100000;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] model(input int mode, input int o, input int shift);
    longint s;
    s = 0;
    for (int st = 0; st < NS; st++)
      for (int i = 0; i < NI; i++)
        s += longint'(act_of(mode, i)) * longint'(wgt(mode, st, o, i));
    s = s >>> shift;
`ifdef FC3_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  always @(posedge clk) begin
    if (!rom_cena0)
      for (int o = 0; o < NO; o++)
        for (int i = 0; i < NI; i++)
          rom_qa0[(NO*NI-1-(o*NI+i))*WW +: WW] <= WW'(wgt(cur_mode, int'(rom_aa0), o, i));
  end

  always @(posedge clk) begin
    if (!rom_cena1)
      for (int o = 0; o < NO; o++)
        for (int i = 0; i < NI; i++)
          rom_qa1[(NO*NI-1-(o*NI+i))*WW +: WW] <= WW'(wgt(cur_mode, int'(rom_aa1), o, i));
  end

  // ---------------- ROM-port monitor on dut0 ----------------
  int   cyc = 0;
  logic mon_clr;
  int   fetch_cnt [NS];
  int   bad_addr, dbl_low;
  logic prev_low;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mon_clr) begin
      for (int k = 0; k < NS; k++) fetch_cnt[k] <= 0;
      bad_addr <= 0;
      dbl_low  <= 0;
      prev_low <= 1'b0;
    end else begin
      if (!rom_cena0) begin
        if (int'(rom_aa0) < NS) fetch_cnt[int'(rom_aa0)] <= fetch_cnt[int'(rom_aa0)] + 1;
        else bad_addr <= bad_addr + 1;
        if (prev_low) dbl_low <= dbl_low + 1;
      end
      prev_low <= !rom_cena0;
    end
  end

  // ---------------- checking ----------------
  typedef struct {
    int          mode;
    int          hold;
    logic [31:0] e0_s0, e1_s0, e0_s16, e1_s16;
  } vec_t;

  vec_t vecs [5];
  vec_t sb_q [$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"},  {63'd0, in_ready0},  64'd1);
    chk({tag, "_rom_cena"},  {63'd0, rom_cena0},  64'd1);
    chk({tag, "_rom_aa"},    {52'd0, rom_aa0},    64'd0);
    chk({tag, "_out_valid"}, {63'd0, out_valid0}, 64'd0);
    chk({tag, "_out_data0"}, out_data0,           64'd0);
    chk({tag, "_out_data1"}, out_data1,           64'd0);
  endtask

  task automatic drive_frame(input int mode, input int nsteps,
                             output int first_hs, output int bad_gap);
    int n, guard, last;
    n = 0; guard = 0; last = 0; bad_gap = 0; first_hs = -1;
    cur_mode = mode;
    for (int i = 0; i < NI; i++) in_act[(NI-1-i)*WA +: WA] = WA'(act_of(mode, i));
    in_valid = 1'b1;
    while (n < nsteps && guard < 10 * nsteps + 20) begin
      @(negedge clk);
      guard++;
      if (in_ready0) begin
        if (n == 0) first_hs = cyc + 1;
        else if (cyc + 1 - last != 4) bad_gap++;
        last = cyc + 1;
        n++;
        if (n == nsteps) begin
          @(posedge clk);
          #1 in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    chk("handshakes_done", n, nsteps);
  endtask

  task automatic collect(input int first_hs, input int hold);
    vec_t v;
    int   guard, bad;
    logic [WO*NO-1:0] d0, d1;
    guard = 0; bad = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!out_valid0 && guard < 400);
    chk("out_valid_seen", {63'd0, out_valid0}, 64'd1);
    chk("latency", cyc - first_hs, 4 * NS - 1);
    chk("out_valid_shift16", {63'd0, out_valid1}, 64'd1);
    chk("sb_nonempty", (sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      v = sb_q.pop_front();
      chk($sformatf("m%0d_s0_o0", v.mode),  out_data0[63:32], v.e0_s0);
      chk($sformatf("m%0d_s0_o1", v.mode),  out_data0[31:0],  v.e1_s0);
      chk($sformatf("m%0d_s16_o0", v.mode), out_data1[63:32], v.e0_s16);
      chk($sformatf("m%0d_s16_o1", v.mode), out_data1[31:0],  v.e1_s16);
    end
    d0 = out_data0;
    d1 = out_data1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (out_data0 !== d0 || out_data1 !== d1 || out_valid0 !== 1'b1 || in_ready0 !== 1'b0)
        bad++;
    end
    if (hold > 0) chk("backpressure_hold", bad, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("out_valid_drop", {63'd0, out_valid0}, 64'd0);
    chk("in_ready_after_out", {63'd0, in_ready0}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fh, gaps, badf, tot;

    vecs[0] = '{mode: 0, hold: 0,  e0_s0: 32'd384,  e1_s0: 32'd384,  e0_s16: 32'd0, e1_s16: 32'd0};
    vecs[1] = '{mode: 1, hold: 0,  e0_s0: 32'd4416, e1_s0: 32'd8832, e0_s16: 32'd0, e1_s16: 32'd0};
`ifdef FC3_SAT_EN
    vecs[2] = '{mode: 2, hold: 20, e0_s0: 32'd2147483647, e1_s0: 32'd2147483647,
                e0_s16: 32'd25165824, e1_s16: 32'd25165824};
`else
    vecs[2] = '{mode: 2, hold: 20, e0_s0: 32'd0, e1_s0: 32'd0,
                e0_s16: 32'd25165824, e1_s16: 32'd25165824};
`endif
    vecs[3] = '{mode: 4, hold: 3,  e0_s0: 32'hFFFF_FE80, e1_s0: 32'hFFFF_FE80,
                e0_s16: 32'hFFFF_FFFF, e1_s16: 32'hFFFF_FFFF};
    vecs[4] = '{mode: 3, hold: 1,  e0_s0: model(3, 0, 0), e1_s0: model(3, 1, 0),
                e0_s16: model(3, 0, 16), e1_s16: model(3, 1, 16)};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_act = '0; mon_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset");
    rst = 1'b0;

    for (int vi = 0; vi < 5; vi++) begin
      mon_clr = 1'b1;
      @(posedge clk);
      #1 mon_clr = 1'b0;
      sb_q.push_back(vecs[vi]);
      drive_frame(vecs[vi].mode, NS, fh, gaps);
      chk($sformatf("m%0d_hs_spacing", vecs[vi].mode), gaps, 0);
      collect(fh, vecs[vi].hold);
      if (vecs[vi].mode == 1) begin
        badf = 0; tot = 0;
        for (int k = 0; k < NS; k++) begin
          if (fetch_cnt[k] != 1) badf++;
          tot += fetch_cnt[k];
        end
        chk("addr_each_once", badf, 0);
        chk("addr_total", tot, NS);
        chk("addr_out_of_range", bad_addr, 0);
        chk("cena_single_cycle", dbl_low, 0);
      end
    end

    // abort inside step 10, then a clean frame
    drive_frame(0, 11, fh, gaps);
    #7 rst = 1'b1;
    #1 check_reset_state("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.push_back(vecs[0]);
    drive_frame(0, NS, fh, gaps);
    collect(fh, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
